// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - shared types and helpers for the column configuration stage
package fabric_cfg_pkg;

  localparam int FRAME_SELECT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - frame index to one-hot strobe with out-of-range flag
module frame_strobe_decoder
  import fabric_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = FRAME_SELECT_WIDTH
) (
  input  logic [FrameSelectWidth-1:0] frame,
  output logic [MaxFramesPerCol-1:0]  onehot,
  output logic                        out_of_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot[i] = (32'(frame) == i);
    end
    out_of_range = (32'(frame) >= MaxFramesPerCol);
  end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// rtl/frame_strobe_sequencer.sv - timed one-hot FrameStrobe sequencer for one fabric column
// Optional FRAME_STROBE_COUNT_EN adds a saturating strobe_count output.
module frame_strobe_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = FRAME_SELECT_WIDTH,
  parameter int Col              = 0,
  parameter int SettleCycles     = 1,
  parameter int PulseCycles      = 2,
  parameter int HoldCycles       = 1
) (
  input  logic                        UserCLK,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [FrameSelectWidth-1:0] req_col,
  input  logic [FrameSelectWidth-1:0] req_frame,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                        busy,
  output logic                        err
`ifdef FRAME_STROBE_COUNT_EN
  ,
  output logic [15:0]                 strobe_count
`endif
);

  localparam int MaxPhase = (SettleCycles > PulseCycles)
                            ? ((SettleCycles > HoldCycles) ? SettleCycles : HoldCycles)
                            : ((PulseCycles > HoldCycles) ? PulseCycles : HoldCycles);
  localparam int CntW = clog2(MaxPhase + 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] PulseLoad  = CntW'(PulseCycles - 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldCycles - 1);

  state_t                      state, state_nx;
  logic [CntW-1:0]             cnt, cnt_nx;
  logic [FrameSelectWidth-1:0] frame_q;
  logic [FrameSelectWidth-1:0] dec_frame;
  logic [MaxFramesPerCol-1:0]  dec_onehot;
  logic                        dec_oor;
  logic                        run_q;
  logic                        accept;
  logic                        col_hit;
  logic                        load_frame;
  logic                        err_nx;

  // Ready is held low until the first edge after reset release.
  assign req_ready = run_q && (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign col_hit   = (req_col == FrameSelectWidth'(Col));
  assign dec_frame = (state == IDLE) ? req_frame : frame_q;

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .FrameSelectWidth(FrameSelectWidth)
  ) u_decoder (
    .frame       (dec_frame),
    .onehot      (dec_onehot),
    .out_of_range(dec_oor)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load_frame = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && col_hit) begin
          if (dec_oor) begin
            err_nx = 1'b1;
          end else begin
            state_nx   = SETUP;
            cnt_nx     = SettleLoad;
            load_frame = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = PulseLoad;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = HoldLoad;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // The strobe register is the registered image of STROBE, so it trails the state by one edge.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_q     <= '0;
      FrameStrobe <= '0;
      err         <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      run_q       <= 1'b1;
      err         <= err_nx;
      FrameStrobe <= (state == STROBE) ? dec_onehot : '0;
      if (load_frame) begin
        frame_q <= req_frame;
      end
    end
  end

`ifdef FRAME_STROBE_COUNT_EN
  logic strobe_entry;
  assign strobe_entry = (state == SETUP) && (cnt == '0);

  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      strobe_count <= '0;
    end else if (strobe_entry && (strobe_count != 16'hFFFF)) begin
      strobe_count <= strobe_count + 16'd1;
    end
  end
`endif

endmodule
